// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, 2-flop row sync, scan-level debounce, keycode encode.
// Optional held-key auto-repeat is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_PERIOD  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       keystrobe,
    output logic [3:0] keycode,
    output logic       key_down
);
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DBW  = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

    logic [3:0]      row_meta, row_sync;
    logic [DIVW-1:0] div_cnt;
    logic [1:0]      col;
    logic [2:0][3:0] samp;
    logic [3:0][3:0] scan_vec;
    logic            scan_done;
    logic            dwell_end;

    assign dwell_end = (div_cnt == DIVW'(SCAN_DIV - 1));

    // Rows are sampled on the last dwell cycle; the column-3 sample completes the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            div_cnt   <= '0;
            col       <= 2'd0;
            col_n     <= 4'b1110;
            samp      <= '0;
            scan_vec  <= '0;
            scan_done <= 1'b0;
        end else begin
            row_meta  <= row_n;
            row_sync  <= row_meta;
            scan_done <= 1'b0;
            if (dwell_end) begin
                div_cnt <= '0;
                col     <= col + 2'd1;
                col_n   <= {col_n[2:0], col_n[3]};
                case (col)
                    2'd0: samp[0] <= ~row_sync;
                    2'd1: samp[1] <= ~row_sync;
                    2'd2: samp[2] <= ~row_sync;
                    default: begin
                        scan_vec  <= {~row_sync, samp};
                        scan_done <= 1'b1;
                    end
                endcase
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        key_map = 4'd0;
        case ({r, c})
            4'h0: key_map = 4'd1;   4'h1: key_map = 4'd2;
            4'h2: key_map = 4'd3;   4'h3: key_map = 4'd15;
            4'h4: key_map = 4'd4;   4'h5: key_map = 4'd5;
            4'h6: key_map = 4'd6;   4'h7: key_map = 4'd14;
            4'h8: key_map = 4'd7;   4'h9: key_map = 4'd8;
            4'hA: key_map = 4'd9;   4'hB: key_map = 4'd13;
            4'hC: key_map = 4'd10;  4'hD: key_map = 4'd0;
            4'hE: key_map = 4'd11;  default: key_map = 4'd12;
        endcase
    endfunction

    logic [4:0] hits;
    logic [1:0] hit_r, hit_c;
    res_t       scan_res;
    logic [3:0] scan_code;

    always_comb begin
        hits  = '0;
        hit_r = '0;
        hit_c = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (scan_vec[c][r]) begin
                    hits  = hits + 5'd1;
                    hit_r = 2'(r);
                    hit_c = 2'(c);
                end
        scan_res  = (hits == 5'd0) ? RES_NONE : (hits == 5'd1) ? RES_SINGLE : RES_MULTI;
        scan_code = key_map(hit_r, hit_c);
    end

    state_t         state;
    logic [3:0]     cand;
    logic [DBW-1:0] db_cnt, rel_cnt, db_next, rel_next;

    assign db_next  = db_cnt + 1'b1;
    assign rel_next = rel_cnt + 1'b1;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [RPW-1:0] rpt_cnt, rpt_next;
    logic           rpt_started;
    assign rpt_next = rpt_cnt + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            db_cnt    <= '0;
            rel_cnt   <= '0;
            keystrobe <= 1'b0;
            keycode   <= '0;
            key_down  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_started <= 1'b0;
`endif
        end else begin
            keystrobe <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (scan_res == RES_SINGLE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= HELD;
                                keycode   <= scan_code;
                                keystrobe <= 1'b1;
                                key_down  <= 1'b1;
                            end else begin
                                state  <= PRESS_DB;
                                cand   <= scan_code;
                                db_cnt <= DBW'(1);
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (scan_res == RES_SINGLE && scan_code == cand) begin
                            if (db_next == DBW'(DEBOUNCE_SCANS)) begin
                                state     <= HELD;
                                keycode   <= cand;
                                keystrobe <= 1'b1;
                                key_down  <= 1'b1;
                                db_cnt    <= '0;
                            end else begin
                                db_cnt <= db_next;
                            end
                        end else if (scan_res == RES_SINGLE) begin
                            cand   <= scan_code;
                            db_cnt <= DBW'(1);
                        end else begin
                            state  <= IDLE;
                            db_cnt <= '0;
                        end
                    end
                    HELD: begin
                        // Any contact, even a different key, holds off the release.
                        if (scan_res == RES_NONE) begin
                            if (rel_next == DBW'(DEBOUNCE_SCANS)) begin
                                key_down <= 1'b0;
                                state    <= IDLE;
                                rel_cnt  <= '0;
                            end else begin
                                rel_cnt <= rel_next;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (scan_res == RES_SINGLE && scan_code == keycode) begin
                            if (rpt_next == (rpt_started ? RPW'(REPEAT_PERIOD) : RPW'(REPEAT_DELAY))) begin
                                keystrobe   <= 1'b1;
                                rpt_cnt     <= '0;
                                rpt_started <= 1'b1;
                            end else begin
                                rpt_cnt <= rpt_next;
                            end
                        end else begin
                            rpt_cnt     <= '0;
                            rpt_started <= 1'b0;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: key table, directed corner sequences, random key traffic vs scan-level model.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int RD       = 4;
    localparam int RP       = 2;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       keystrobe;
    logic [3:0] keycode;
    logic       key_down;
    logic [15:0] keys = '0;   // bit r*4+c = key at row r, col c pressed

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB),
                     .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .keystrobe(keystrobe), .keycode(keycode), .key_down(key_down));

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to a column being driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    typedef struct { int cyc; logic [3:0] code; } strobe_t;
    typedef struct { int r; int c; logic [3:0] code; } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc;
    strobe_t act_q[$];
    strobe_t exp_q[$];
    logic prev_ks = 1'b0;

    int keymap[16] = '{1, 2, 3, 15, 4, 5, 6, 14, 7, 8, 9, 13, 10, 0, 11, 12};

    // Model state, one step per full scan
    int hist[$];
    bit held;
    int scan_idx;
    logic [3:0] held_code;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge clk) begin
        if (keystrobe) begin
            act_q.push_back('{cyc: cyc, code: keycode});
            tests++;
            if (prev_ks) begin
                fails++;
                $display("FAIL strobe_width: keystrobe high two cycles running at cycle %0d, required single-cycle pulse", cyc);
            end
        end
        prev_ks = keystrobe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] kb(input int r, input int c);
        logic [15:0] one = 16'd1;
        return one << (r*4 + c);
    endfunction

    function automatic int classify(input logic [15:0] ks);
        int idx = 0;
        if ($countones(ks) == 0) return -1;
        if ($countones(ks) > 1)  return -2;
        for (int i = 0; i < 16; i++) if (ks[i]) idx = i;
        return keymap[idx];
    endfunction

    function automatic bit tail_all(input int v, input int n);
        if (hist.size() < n) return 1'b0;
        for (int i = hist.size() - n; i < hist.size(); i++) if (hist[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input int res);
        hist.push_back(res);
        if (!held) begin
            if (res >= 0 && tail_all(res, DEB)) begin
                exp_q.push_back('{cyc: SCAN_CYC*scan_idx + 1, code: 4'(res)});
                held      = 1'b1;
                held_code = 4'(res);
                hist.delete();
            end
        end else if (tail_all(-1, DEB)) begin
            held = 1'b0;
            hist.delete();
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (res == int'(held_code)) begin
            int run = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] == int'(held_code); i--) run++;
            if (run == RD || (run > RD && (run - RD) % RP == 0))
                exp_q.push_back('{cyc: SCAN_CYC*scan_idx + 1, code: held_code});
        end
`endif
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Hold a key set for one full scan, then advance the model by that scan.
    task automatic scan(input logic [15:0] ks);
        keys = ks;
        @(negedge clk);
        chk("key_down", {3'b0, key_down}, {3'b0, held});
        repeat (SCAN_CYC - 1) @(negedge clk);
        scan_idx++;
        model_step(classify(ks));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst col_n", col_n, 4'b1110);
        chk("rst keystrobe", {3'b0, keystrobe}, 4'd0);
        chk("rst keycode", keycode, 4'd0);
        chk("rst key_down", {3'b0, key_down}, 4'd0);
        repeat (2) @(negedge clk);
        held = 1'b0;
        hist.delete();
        scan_idx = 0;
        exp_q.delete();
        act_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic expect_nth(input string name, input int n, input int cyc_e, input logic [3:0] code_e);
        tests++;
        if (act_q.size() <= n) begin
            fails++;
            $display("FAIL %s: only %0d strobes seen, required strobe #%0d at cycle %0d", name, act_q.size(), n, cyc_e);
        end else if (act_q[n].cyc != cyc_e || act_q[n].code !== code_e) begin
            fails++;
            $display("FAIL %s: strobe at cycle %0d code %0d, required cycle %0d code %0d",
                     name, act_q[n].cyc, act_q[n].code, cyc_e, code_e);
        end
    endtask

    task automatic check_strobes(input string name);
        int n;
        repeat (2) @(negedge clk);
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s count: got %0d strobes, required %0d", name, act_q.size(), exp_q.size());
        end
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            tests++;
            if (act_q[i].cyc != exp_q[i].cyc || act_q[i].code !== exp_q[i].code) begin
                fails++;
                $display("FAIL %s #%0d: cycle %0d code %0d, required cycle %0d code %0d",
                         name, i, act_q[i].cyc, act_q[i].code, exp_q[i].cyc, exp_q[i].code);
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tbl[16];
        logic [15:0] cur;
        logic [15:0] ks;
        int sel;

        tbl[0]  = '{0, 0, 4'd1};  tbl[1]  = '{0, 1, 4'd2};  tbl[2]  = '{0, 2, 4'd3};  tbl[3]  = '{0, 3, 4'd15};
        tbl[4]  = '{1, 0, 4'd4};  tbl[5]  = '{1, 1, 4'd5};  tbl[6]  = '{1, 2, 4'd6};  tbl[7]  = '{1, 3, 4'd14};
        tbl[8]  = '{2, 0, 4'd7};  tbl[9]  = '{2, 1, 4'd8};  tbl[10] = '{2, 2, 4'd9};  tbl[11] = '{2, 3, 4'd13};
        tbl[12] = '{3, 0, 4'd10}; tbl[13] = '{3, 1, 4'd0};  tbl[14] = '{3, 2, 4'd11}; tbl[15] = '{3, 3, 4'd12};

        // Every key: press 2 scans, release 2 scans
        for (int i = 0; i < 16; i++) begin
            do_reset();
            scan(kb(tbl[i].r, tbl[i].c));
            scan(kb(tbl[i].r, tbl[i].c));
            scan('0);
            scan('0);
            expect_nth($sformatf("map r%0d c%0d", tbl[i].r, tbl[i].c), 0, 33, tbl[i].code);
            check_strobes("map");
        end

        // Hold '6', release, then press 'clear'
        do_reset();
        repeat (6) scan(kb(1, 2));
        scan('0);
        scan('0);
        chk("keycode held after release", keycode, 4'd6);
        scan(kb(3, 0));
        scan(kb(3, 0));
        scan('0);
        scan('0);
        expect_nth("hold6", 0, 33, 4'd6);
        expect_nth("clear after release", 1, 161, 4'd10);
        check_strobes("hold_release");

        // Bounce on '+'
        do_reset();
        scan(kb(0, 3));
        scan('0);
        scan(kb(0, 3));
        scan(kb(0, 3));
        scan('0);
        scan('0);
        expect_nth("bounce", 0, 65, 4'd15);
        check_strobes("bounce");

        // Two keys together, then one released
        do_reset();
        repeat (3) scan(kb(0, 0) | kb(2, 1));
        scan(kb(0, 0));
        scan(kb(0, 0));
        scan('0);
        scan('0);
        expect_nth("multi", 0, 81, 4'd1);
        check_strobes("multi");

        // Reset while '9' is held
        do_reset();
        repeat (3) scan(kb(2, 2));
        repeat (5) @(negedge clk);
        check_strobes("pre_reset");
        do_reset();
        repeat (3) scan(kb(2, 2));
        scan('0);
        scan('0);
        expect_nth("after reset", 0, 33, 4'd9);
        check_strobes("reset_held");

`ifdef KEYPAD_AUTOREPEAT_EN
        do_reset();
        repeat (12) scan(kb(1, 1));
        scan('0);
        scan('0);
        expect_nth("rpt0", 0, 33, 4'd5);
        expect_nth("rpt1", 1, 97, 4'd5);
        expect_nth("rpt2", 2, 129, 4'd5);
        expect_nth("rpt3", 3, 161, 4'd5);
        expect_nth("rpt4", 4, 193, 4'd5);
        check_strobes("autorepeat");
`endif

        // Random key traffic against the scan-level model
        do_reset();
        cur = kb(1, 1);
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) cur = kb($urandom_range(0, 3), $urandom_range(0, 3));
            if (sel < 3)      ks = '0;
            else if (sel < 9) ks = cur;
            else              ks = cur | kb($urandom_range(0, 3), $urandom_range(0, 3));
            scan(ks);
        end
        scan('0);
        scan('0);
        check_strobes("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
